branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 128 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: per-entry 2-bit saturating counter plus stored target,
// combinational lookup for fetch and resolution/update from MEM with hit/miss statistics.
module branch_predictor #(
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_en,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [31:0]      target_r [ENTRIES];
  logic [1:0]       ctr_r    [ENTRIES];
  logic [CNT_W-1:0] br_count_r;
  logic [CNT_W-1:0] miss_count_r;

  logic [IDX-1:0]   lk_idx_s;
  logic             lk_hit_s;
  logic             lk_taken_s;
  logic [IDX-1:0]   up_idx_s;
  logic             up_hit_s;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    case ({taken, ctr})
      3'b1_11: nxt = 2'b11;
      3'b0_00: nxt = 2'b00;
      default: nxt = taken ? (ctr + 2'd1) : (ctr - 2'd1);
    endcase
    return nxt;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] nxt;
    if (val == CNT_MAX) begin
      nxt = val;
    end else begin
      nxt = val + CNT_ONE;
    end
    return nxt;
  endfunction

  // Fetch-side lookup from registered state only; no bypass from a same-cycle update.
  always_comb begin
    lk_idx_s   = if_pc[IDX+1:2];
    lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == if_pc[31:IDX+2]);
    lk_taken_s = lk_hit_s & ctr_r[lk_idx_s][1];
    pred_taken = lk_taken_s;
    if (lk_taken_s) begin
      pred_target = target_r[lk_idx_s];
    end else begin
      pred_target = if_pc + 32'd4;
    end
  end

  // Resolution side: hit detection for the update and the mispredict/redirect decision.
  always_comb begin
    up_idx_s   = upd_pc[IDX+1:2];
    up_hit_s   = valid_r[up_idx_s] && (tag_r[up_idx_s] == upd_pc[31:IDX+2]);
    mispredict = upd_en & ((upd_taken != upd_pred_taken) |
                           (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
    if (upd_taken) begin
      redirect_pc = upd_target;
    end else begin
      redirect_pc = upd_pc + 32'd4;
    end
  end

  // Predictor table: reset, train on hit, allocate only on a taken miss.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (upd_en) begin
      if (up_hit_s) begin
        ctr_r[up_idx_s] <= ctr_step(ctr_r[up_idx_s], upd_taken);
        if (upd_taken) begin
          target_r[up_idx_s] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_r[up_idx_s]  <= 1'b1;
        tag_r[up_idx_s]    <= upd_pc[31:IDX+2];
        target_r[up_idx_s] <= upd_target;
        ctr_r[up_idx_s]    <= 2'b10;
      end
    end
  end

  // Saturating branch and mispredict statistics; a reset cycle discards the update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      br_count_r   <= {CNT_W{1'b0}};
      miss_count_r <= {CNT_W{1'b0}};
    end else if (upd_en) begin
      br_count_r <= sat_inc(br_count_r);
      if (mispredict) begin
        miss_count_r <= sat_inc(miss_count_r);
      end
    end
  end

  assign br_count   = br_count_r;
  assign miss_count = miss_count_r;

endmodule
